// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
//   Request/response bundle between the control unit (master) and the
//   memory responder (slave).
//
//   Handshake: four-phase. The master raises exactly one of Read/Write and
//   holds it, with Address and MDR_q, until it sees Done. It then drops the
//   request. The slave keeps Done high until it sees both requests low, and
//   then returns to idle. Raising Read and Write together is illegal: it is
//   answered by a one-cycle Err pulse and no access.
//
//   Signals:
//     Read, Write  master->slave  request levels
//     Address      master->slave  word address (from MAR)
//     MDR_q        master->slave  write data (from MDR)
//     Mdatain      slave->master  registered read data (to MDR)
//     Done         slave->master  access complete
//     Busy         slave->master  responder not idle
//     Err          slave->master  illegal-request pulse
// ---------------------------------------------------------------------------
interface mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  logic                  Read;
  logic                  Write;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] MDR_q;
  logic [DATA_WIDTH-1:0] Mdatain;
  logic                  Done;
  logic                  Busy;
  logic                  Err;

  modport master (
    output Read, Write, Address, MDR_q,
    input  Mdatain, Done, Busy, Err
  );

  modport slave (
    input  Read, Write, Address, MDR_q,
    output Mdatain, Done, Busy, Err
  );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the MDR/MAR datapath. Holds a word-addressed
//   RAM of 2**ADDR_WIDTH words, inserts WAIT_STATES stall cycles before each
//   access, and completes with a four-phase Done handshake.
//
//   Ports:
//     clk          system clock, rising edge
//     clr          synchronous active-high reset (RAM contents are kept)
//     bus          slave side of mem_responder_if (Read/Write/Address/MDR_q
//                  in, Mdatain/Done/Busy/Err out)
//     dbg_state_o  current FSM state (0 IDLE, 1 WAIT, 2 ACCESS, 3 DONE)
//
//   Timing: request sampled at edge 0 -> Done and Mdatain valid after edge
//   WAIT_STATES+1. WAIT_STATES must be in 0..15.
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  mem_responder_if.slave    bus,
  output logic [1:0]        dbg_state_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Counter preload; WAIT is skipped entirely when WAIT_STATES is 0, so the
  // preload value only matters for WAIT_STATES >= 1.
  localparam int          WAIT_INIT_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0]  WAIT_INIT   = WAIT_INIT_I[3:0];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   op_write_q, op_write_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   err_q, err_d;

  logic [DATA_WIDTH-1:0]  ram [DEPTH];

  logic req_any;
  logic req_illegal;
  logic req_legal;

  assign req_any     = bus.Read | bus.Write;
  assign req_illegal = bus.Read & bus.Write;
  assign req_legal   = bus.Read ^ bus.Write;

  // -------------------------------------------------------------------------
  // Next-state logic. Request fields are captured only on the IDLE->busy
  // transition, so the requester's inputs are free to move afterwards.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_illegal) begin
          err_d = 1'b1;
        end else if (req_legal) begin
          op_write_d = bus.Write;
          addr_d     = bus.Address;
          wdata_d    = bus.MDR_q;
          if (WAIT_STATES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end

      // Counter is preloaded with WAIT_STATES-1 and leaves at 0, giving
      // exactly WAIT_STATES cycles in this state.
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_ACCESS: begin
        state_d = S_DONE;
      end

      // Stay until the requester has withdrawn both request lines.
      S_DONE: begin
        if (!req_any) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Control and read-data registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      // Mdatain only moves on a read access; it holds through writes.
      if (state_q == S_ACCESS && !op_write_q) begin
        rdata_q <= ram[addr_q];
      end
    end
  end

  // -------------------------------------------------------------------------
  // RAM write port. Kept in its own reset-free block so the array is never
  // cleared; clr still blocks a write that lands on the same edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr && state_q == S_ACCESS && op_write_q) begin
      ram[addr_q] <= wdata_q;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.Mdatain = rdata_q;
  assign bus.Done    = (state_q == S_DONE);
  assign bus.Busy    = (state_q != S_IDLE);
  assign bus.Err     = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Two responders side by side: one with WAIT_STATES=2 and one with
//   WAIT_STATES=0. Read expectations come from a per-instance memory model
//   and flow through exp_q; handshake timing, Busy width, Err and reset
//   behaviour are checked inline.
// ---------------------------------------------------------------------------
module tb_mem_responder;
  localparam int DW = 32;
  localparam int AW = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();
  mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  logic [1:0] st2, st0;

  mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(2)) u_dut2 (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus2),
    .dbg_state_o (st2)
  );

  mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(0)) u_dut0 (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus0),
    .dbg_state_o (st0)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem_m [2][2**AW];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- access helpers (sel = WAIT_STATES of the target) -------
  function automatic int midx(input int sel);
    return (sel == 2) ? 0 : 1;
  endfunction

  function automatic logic f_done(input int sel);
    return (sel == 2) ? bus2.Done : bus0.Done;
  endfunction

  function automatic logic f_busy(input int sel);
    return (sel == 2) ? bus2.Busy : bus0.Busy;
  endfunction

  function automatic logic f_err(input int sel);
    return (sel == 2) ? bus2.Err : bus0.Err;
  endfunction

  function automatic logic [DW-1:0] f_mdata(input int sel);
    return (sel == 2) ? bus2.Mdatain : bus0.Mdatain;
  endfunction

  function automatic logic [1:0] f_state(input int sel);
    return (sel == 2) ? st2 : st0;
  endfunction

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (sel == 2) begin
      bus2.Read = rd; bus2.Write = wr; bus2.Address = a; bus2.MDR_q = d;
    end else begin
      bus0.Read = rd; bus0.Write = wr; bus0.Address = a; bus0.MDR_q = d;
    end
  endtask

  // Full four-phase access. hold = extra cycles the request stays up after
  // Done; jitter = scramble Address/MDR_q every cycle until Done.
  task automatic do_access(input int sel, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input int hold, input logic jitter);
    int n;
    int busy_n;
    logic [DW-1:0] held;
    logic [DW-1:0] exp;
    @(negedge clk);
    drive(sel, !wr, wr, addr, data);
    if (wr) mem_m[midx(sel)][addr] = data;
    else    exp_q.push_back(mem_m[midx(sel)][addr]);
    n = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (f_busy(sel)) busy_n++;
      if (!f_done(sel) && jitter)
        drive(sel, !wr, wr, AW'($urandom_range(0, 15)), $urandom);
    end while (!f_done(sel) && n < 40);
    check("done_latency", 64'(n - 1), 64'(sel + 1));
    if (!wr) begin
      exp = exp_q.pop_front();
      check("rdata", f_mdata(sel), exp);
    end
    held = f_mdata(sel);
    repeat (hold) begin
      @(negedge clk);
      if (f_busy(sel)) busy_n++;
      check("hold_done", f_done(sel), 1);
      check("hold_mdata", f_mdata(sel), held);
    end
    drive(sel, 1'b0, 1'b0, addr, data);
    @(negedge clk);
    if (f_busy(sel)) busy_n++;
    check("idle_busy", f_busy(sel), 0);
    check("idle_done", f_done(sel), 0);
    check("busy_cycles", 64'(busy_n), 64'(sel + 2 + hold));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] v_old, v_new, md_before;

    drive(2, 1'b0, 1'b0, '0, '0);
    drive(0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy2", bus2.Busy, 0);
    check("rst_done2", bus2.Done, 0);
    check("rst_err2", bus2.Err, 0);
    check("rst_mdata2", bus2.Mdatain, 0);
    check("rst_state2", st2, 0);
    check("rst_busy0", bus0.Busy, 0);
    check("rst_mdata0", bus0.Mdatain, 0);
    clr = 1'b0;

    // Write then read, WAIT_STATES=2
    do_access(2, 1'b1, 9'h05A, 32'hDEADBEEF, 0, 1'b0);
    do_access(2, 1'b0, 9'h05A, 32'h0, 0, 1'b0);

    // WAIT_STATES=0: preload then read top word
    do_access(0, 1'b1, 9'h1FF, 32'h12345678, 0, 1'b0);
    do_access(0, 1'b0, 9'h1FF, 32'h0, 0, 1'b0);

    // Handshake hold: Read stays up 5 cycles after Done
    do_access(2, 1'b0, 9'h05A, 32'h0, 5, 1'b0);
    check("hold_state_idle", st2, 0);

    // Illegal request
    do_access(2, 1'b1, 9'h020, 32'hC0FFEE11, 0, 1'b0);
    do_access(2, 1'b0, 9'h05A, 32'h0, 0, 1'b0);
    md_before = mem_m[0][9'h05A];
    @(negedge clk);
    drive(2, 1'b1, 1'b1, 9'h020, 32'h0BAD0BAD);
    @(negedge clk);
    check("err_pulse", bus2.Err, 1);
    check("err_busy", bus2.Busy, 0);
    check("err_done", bus2.Done, 0);
    drive(2, 1'b0, 1'b0, 9'h020, 32'h0);
    @(negedge clk);
    check("err_clear", bus2.Err, 0);
    check("err_busy_after", bus2.Busy, 0);
    check("err_mdata", bus2.Mdatain, md_before);
    do_access(2, 1'b0, 9'h020, 32'h0, 0, 1'b0);

    // Reset during WAIT aborts a pending write to 0x010
    v_old = $urandom;
    v_new = ~v_old;
    do_access(2, 1'b1, 9'h010, v_old, 0, 1'b0);
    @(negedge clk);
    drive(2, 1'b0, 1'b1, 9'h010, v_new);
    @(negedge clk);
    check("pre_rst_busy", bus2.Busy, 1);
    check("pre_rst_state", st2, 1);
    clr = 1'b1;
    drive(2, 1'b0, 1'b0, 9'h010, v_new);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    check("mid_rst_busy", bus2.Busy, 0);
    check("mid_rst_done", bus2.Done, 0);
    check("mid_rst_mdata", bus2.Mdatain, 0);
    check("mid_rst_state", st2, 0);
    do_access(2, 1'b0, 9'h010, 32'h0, 0, 1'b0);

    // Input stability: scramble Address/MDR_q during WAIT of a write to 0x003
    for (int i = 0; i < 16; i++) do_access(2, 1'b1, AW'(i), $urandom, 0, 1'b0);
    do_access(2, 1'b1, 9'h003, 32'hA5A5A5A5, 0, 1'b1);
    for (int i = 0; i < 16; i++) do_access(2, 1'b0, AW'(i), 32'h0, 0, 1'b0);

    // Mixed random traffic on both instances, confined to written words
    for (int i = 0; i < 12; i++) begin
      int sel;
      logic [AW-1:0] a;
      sel = ($urandom_range(0, 1) == 1) ? 2 : 0;
      a   = AW'($urandom_range(32, 40));
      do_access(sel, 1'b1, a, $urandom, $urandom_range(0, 2), 1'b1);
      do_access(sel, 1'b0, a, 32'h0, $urandom_range(0, 2), 1'b0);
    end

    check("exp_q_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
